// File: rtl/byte_striping_pkg.sv
// Shared defaults and types for the byte striping / un-striping pair.
// The saturating counter helper keeps the error-count update in one place.
package byte_striping_pkg;

    localparam int LANES_DEF = 4;
    localparam int WIDTH_DEF = 8;
    localparam int ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/word_fifo2.sv
// Two-entry word buffer; occupancy is tracked as a small FSM.
// A push while full is ignored, and a pop while empty is ignored.
module word_fifo2
    import byte_striping_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);

    occ_e          r_state;
    occ_e          w_next;
    logic [DW-1:0] r_mem [2];
    logic          r_rd_ptr;
    logic          r_wr_ptr;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = push && (r_state != OCC_FULL);
    assign w_do_pop  = pop  && (r_state != OCC_EMPTY);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= OCC_EMPTY;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            OCC_EMPTY: if (push) w_next = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop)      w_next = OCC_FULL;
                else if (pop && !push) w_next = OCC_EMPTY;
            end
            OCC_FULL:  if (pop) w_next = OCC_ONE;
            default:   w_next = OCC_EMPTY;
        endcase
    end

    always_comb begin
        full  = (r_state == OCC_FULL);
        empty = (r_state == OCC_EMPTY);
        head  = r_mem[r_rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
        end
    end

    // NOTE: storage is not reset; the occupancy state alone decides whether an entry is meaningful.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/byte_un_striping_param.sv
// Collects complete striped words and replays them one lane symbol per transfer,
// lane 0 first; partial lane_valid vectors are dropped and counted.
module byte_un_striping_param
    import byte_striping_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] lane_data,
    input  logic [LANES-1:0]       lane_valid,
    output logic                   in_ready,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       data_out,
    output logic                   valid_out,
    output logic                   align_err,
    output logic [ERR_CNT_W-1:0]   err_count
);

    localparam int IDX_W = $clog2(LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    logic                   w_full;
    logic                   w_empty;
    logic [LANES*WIDTH-1:0] w_head;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_xfer;
    logic                   w_partial;
    logic [WIDTH-1:0]       w_sym;
    logic [IDX_W-1:0]       r_lane_idx;
    logic                   r_align_err;
    logic [ERR_CNT_W-1:0]   r_err_count;

    assign in_ready  = !w_full;
    assign valid_out = !w_empty;
    assign w_push    = (&lane_valid) && in_ready;
    assign w_partial = (|lane_valid) && !(&lane_valid);
    assign w_xfer    = valid_out && out_ready;
    assign w_pop     = w_xfer && (r_lane_idx == LAST_IDX);

    word_fifo2 #(.DW(LANES*WIDTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (lane_data),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    // NOTE: default before the loop so the mux never infers a latch.
    always_comb begin
        w_sym = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_lane_idx == IDX_W'(i)) w_sym = w_head[i*WIDTH +: WIDTH];
        end
    end

    assign data_out  = valid_out ? w_sym : '0;
    assign align_err = r_align_err;
    assign err_count = r_err_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lane_idx  <= '0;
            r_align_err <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_xfer) r_lane_idx <= (r_lane_idx == LAST_IDX) ? '0 : r_lane_idx + 1'b1;
            r_align_err <= w_partial;
            if (w_partial) r_err_count <= sat_inc(r_err_count);
        end
    end

endmodule

// File: tb/tb_byte_un_striping_param.sv
// Directed bench for byte_un_striping_param with LANES=4, WIDTH=8.
// Inputs change 1 ns after each rising edge; outputs are checked at the same point.
module tb_byte_un_striping_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] lane_data;
    logic [3:0]  lane_valid;
    logic        in_ready;
    logic        out_ready;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        align_err;
    logic [7:0]  err_count;

    int n_cmp = 0;
    int n_err = 0;

    byte_un_striping_param #(.LANES(4), .WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .lane_data  (lane_data),
        .lane_valid (lane_valid),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .align_err  (align_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp8 [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    logic       rdy8 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        reset      = 1'b1;
        lane_data  = '0;
        lane_valid = '0;
        out_ready  = 1'b0;
        step();
        step();
        check("rst_valid", valid_out, 0);
        check("rst_data", data_out, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_err_count", err_count, 0);
        check("rst_align_err", align_err, 0);
        reset = 1'b0;

        // single word, lane 0 appears right after the accepting edge
        out_ready  = 1'b1;
        lane_data  = 32'h44332211;
        lane_valid = 4'hF;
        step();
        lane_valid = 4'h0;
        check("single_l0", data_out, 32'h11);
        check("single_v0", valid_out, 1);
        step(); check("single_l1", data_out, 32'h22);
        step(); check("single_l2", data_out, 32'h33);
        step(); check("single_l3", data_out, 32'h44);
        step();
        check("single_done_valid", valid_out, 0);
        check("single_done_data", data_out, 0);

        // back-to-back words into a stalled output
        out_ready  = 1'b0;
        lane_data  = 32'h04030201;
        lane_valid = 4'hF;
        step();
        check("bp_ready_after1", in_ready, 1);
        lane_data = 32'h08070605;
        step();
        check("bp_ready_after2", in_ready, 0);
        lane_data = 32'h0C0B0A09;
        step();
        check("bp_held_ready", in_ready, 0);
        check("bp_held_data", data_out, 32'h01);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("bp_sym%0d", i), data_out, exp8[i]);
            check($sformatf("bp_valid%0d", i), valid_out, 1);
            check($sformatf("bp_ready%0d", i), in_ready, rdy8[i]);
            step();
            if (i == 4) lane_valid = 4'h0;
        end
        check("bp_third_l0", data_out, 32'h09);
        step(); check("bp_third_l1", data_out, 32'h0A);
        step(); check("bp_third_l2", data_out, 32'h0B);
        step(); check("bp_third_l3", data_out, 32'h0C);
        step(); check("bp_drained", valid_out, 0);

        // partial lane_valid vectors
        lane_valid = 4'b0101;
        lane_data  = 32'hDEADBEEF;
        step();
        check("part_align", align_err, 1);
        check("part_count", err_count, 1);
        check("part_no_out", valid_out, 0);
        lane_valid = 4'h0;
        step();
        check("part_align_once", align_err, 0);
        check("part_count_hold", err_count, 1);
        lane_valid = 4'b0101;
        for (int i = 0; i < 300; i++) step();
        lane_valid = 4'h0;
        check("part_saturate", err_count, 255);
        step();
        check("part_sat_hold", err_count, 255);
        check("part_align_clear", align_err, 0);

        // stall in the middle of a word
        out_ready  = 1'b1;
        lane_data  = 32'h44332211;
        lane_valid = 4'hF;
        step();
        lane_valid = 4'h0;
        check("stall_l0", data_out, 32'h11);
        step();
        check("stall_l1", data_out, 32'h22);
        out_ready = 1'b0;
        step(); check("stall_hold1", data_out, 32'h22);
        step(); check("stall_hold2", data_out, 32'h22);
        check("stall_hold_valid", valid_out, 1);
        out_ready = 1'b1;
        step(); check("stall_l2", data_out, 32'h33);
        step(); check("stall_l3", data_out, 32'h44);
        step(); check("stall_done", valid_out, 0);

        // reset mid-word with a second word buffered
        lane_data  = 32'h14131211;
        lane_valid = 4'hF;
        step();
        check("mid_l0", data_out, 32'h11);
        lane_data = 32'h24232221;
        step();
        check("mid_l1", data_out, 32'h12);
        check("mid_full", in_ready, 0);
        lane_valid = 4'b0011;
        reset      = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_valid", valid_out, 0);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_count", err_count, 0);
        check("mid_rst_align", align_err, 0);
        lane_data  = 32'h34333231;
        lane_valid = 4'hF;
        step();
        lane_valid = 4'h0;
        check("mid_next_l0", data_out, 32'h31);
        step();
        check("mid_next_l1", data_out, 32'h32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/byte_un_striping_param.md
BYTE_UN_STRIPING_PARAM -- requirements
Module: byte_un_striping_param

Interface
REQ-001 Parameter LANES, default 4: number of striped input lanes, legal range 2..8.
REQ-002 Parameter WIDTH, default 8: bits per lane symbol.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-005 lane_data  input  LANES*WIDTH  striped word; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-006 lane_valid  input  LANES  per-lane valid; bit i qualifies lane i.
REQ-007 in_ready  output  1  block can accept a complete striped word this cycle.
REQ-008 out_ready  input  1  downstream accepts data_out this cycle.
REQ-009 data_out  output  WIDTH  un-striped serial symbol.
REQ-010 valid_out  output  1  data_out is valid.
REQ-011 align_err  output  1  one-cycle pulse: partial lane_valid vector was dropped.
REQ-012 err_count  output  8  saturating count of dropped partial words.

Function
REQ-013 Accept: on an edge where lane_valid is all ones and in_ready=1, the word SHALL be pushed into a 2-entry word buffer.
REQ-014 in_ready SHALL be 1 exactly when buffer occupancy < 2; it is derived from registered state only and does not depend on same-cycle pop.
REQ-015 lane_valid all zeros: no push, no error.
REQ-016 Partial vector (nonzero, not all ones): the word is dropped, align_err=1 for the following cycle, and err_count increments, saturating at 255; a partial vector while in_ready=0 is also counted.
REQ-017 Occupancy states EMPTY(0), ONE(1), FULL(2): push only -> +1; pop only -> -1; push and pop on the same edge (occupancy 1) -> stays ONE; FULL ignores any push.
REQ-018 Output order: lane 0 first, then lane 1, up to lane LANES-1, selected from the buffer head by a lane index counter of width clog2(LANES).
REQ-019 valid_out SHALL be 1 whenever occupancy != 0; data_out = head[lane_idx] when valid_out=1, else all zeros.
REQ-020 Outputs are functions of registered state only; no combinational path from any input to data_out/valid_out.
REQ-021 Transfer occurs when valid_out=1 and out_ready=1: lane_idx increments; at lane_idx=LANES-1 it wraps to 0 and the head word is popped.
REQ-022 valid_out=1 and out_ready=0: data_out, valid_out and lane_idx SHALL hold stable.
REQ-023 Latency: a word accepted on edge k SHALL present lane 0 on data_out immediately after edge k when the buffer was EMPTY.
REQ-024 Throughput: with out_ready held at 1 and a word offered every LANES cycles, valid_out SHALL remain 1 with no bubble between words.

Reset
REQ-025 On reset=1 at an edge: occupancy 0, lane_idx 0, err_count 0, align_err 0; hence valid_out=0, data_out=0, in_ready=1 after that edge.
REQ-026 Reset mid-word SHALL discard buffered words and the partially sent word; the first word after reset starts at lane 0.
REQ-027 Reset has priority over simultaneous accept, pop and error events.

Structure
REQ-028 Package byte_striping_pkg SHALL hold the defaults LANES_DEF=4, WIDTH_DEF=8 and ERR_CNT_W=8, shared with the striping-side block.
REQ-029 The 2-entry buffer SHALL be a sub-module word_fifo2 (parameter DW=LANES*WIDTH; push, pop, full, empty, head).

Verification (LANES=4, WIDTH=8)
REQ-030 Single word lane_data=0x44332211, lane_valid=4'hF, out_ready=1 -> data_out 0x11,0x22,0x33,0x44 on four consecutive cycles, then valid_out=0, data_out=0x00.
REQ-031 Three words offered back-to-back with out_ready=0 -> in_ready falls after 2 accepts, third held; release out_ready -> 8 symbols without a gap, then third word accepted.
REQ-032 lane_valid=4'b0101 -> no output, align_err pulses once, err_count=1; 300 such cycles -> err_count=255.
REQ-033 out_ready toggled 1,0,0,1 during a word -> data_out holds the 0x22 symbol through the stall, and order is preserved.
REQ-034 reset=1 after two symbols sent with one word buffered -> next cycle valid_out=0, in_ready=1, err_count=0; next word starts at its lane 0.
